// File: rtl/penalty_pkg.sv
// Shared constants for the penalty-shootout display path: active-low
// 7-segment patterns ({g,f,e,d,c,b,a}), winner codes and FSM state codes.
package penalty_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Index 0 is the leftmost element of the concatenation.
  localparam logic [0:7][6:0] SEG_DIGITS = {
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78
  };

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_FWD  = 2'b01;
  localparam logic [1:0] WIN_GK   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PLAY   = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;

endpackage

// File: rtl/seg7_decode.sv
// 3-bit value to active-low 7-segment pattern. Purely combinational so any
// display block can drop it in front of its own output register.
module seg7_decode
  import penalty_pkg::*;
(
  input  logic [2:0] val,
  output logic [6:0] seg
);

  // Table lookup; 6 and 7 decode as ordinary digits.
  assign seg = SEG_DIGITS[val];

endmodule

// File: rtl/penalty_scoreboard.sv
// Scoreboard for the penalty-shootout core: freezes the final score on the
// first rising edge of the end flag, computes the winner and scans a 4-digit
// active-low 7-segment display (idx0 gk, idx1 fwd, idx2 dash, idx3 shots).
// Optional macro SCOREBOARD_BLINK_EN: blink the winner's digit(s) in RESULT.
module penalty_scoreboard
  import penalty_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] fwd_score,
  input  logic [2:0] gk_score,
  input  logic [2:0] cont3p,
  input  logic [2:0] cont5p,
  input  logic       fin3p,
  input  logic       fin5p,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [1:0] winner,
  output logic       done
);

  localparam int PW = $clog2(SCAN_DIV);

  if (SCAN_DIV < 2 || BLINK_DIV < 1) begin : g_bad_param
    $error("penalty_scoreboard: SCAN_DIV must be >= 2 and BLINK_DIV >= 1");
  end

  logic [2:0]    shots;
  logic          fin, fin_q, fin_rise;
  logic [1:0]    state, state_nxt;
  logic          in_res;
  logic [2:0]    frz_fwd, frz_gk, frz_shots;
  logic [PW-1:0] presc;
  logic          tick;
  logic [1:0]    idx, idx_nxt;
  logic [2:0]    dval;
  logic [6:0]    dseg;
  logic          blank;

  assign shots    = cont3p | cont5p;
  assign fin      = fin3p | fin5p;
  assign fin_rise = fin & ~fin_q;
  assign in_res   = (state == ST_RESULT);
  assign tick     = (presc == PW'(SCAN_DIV - 1));
  assign idx_nxt  = tick ? idx + 2'd1 : idx;

  // Next state: an end-flag rise wins over the idle->play start condition.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (fin_rise)                                          state_nxt = ST_RESULT;
        else if (shots != 3'd0 || fwd_score != 3'd0 || gk_score != 3'd0) state_nxt = ST_PLAY;
      end
      ST_PLAY:   if (fin_rise) state_nxt = ST_RESULT;
      default:   state_nxt = ST_RESULT;
    endcase
  end

  // State, end-flag history, freeze registers and final result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      fin_q     <= 1'b0;
      frz_fwd   <= 3'd0;
      frz_gk    <= 3'd0;
      frz_shots <= 3'd0;
      winner    <= WIN_NONE;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      fin_q <= fin;
      if (fin_rise && !in_res) begin
        frz_fwd   <= fwd_score;
        frz_gk    <= gk_score;
        frz_shots <= shots;
        done      <= 1'b1;
        if (fwd_score > gk_score)      winner <= WIN_FWD;
        else if (gk_score > fwd_score) winner <= WIN_GK;
        else                           winner <= WIN_TIE;
      end
    end
  end

  // Scan prescaler and digit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      idx   <= 2'd0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      idx   <= idx_nxt;
    end
  end

  // Pick the value for the digit being loaded into the output register.
  always_comb begin
    dval = 3'd0;
    case (idx_nxt)
      2'd0:    dval = in_res ? frz_gk    : gk_score;
      2'd1:    dval = in_res ? frz_fwd   : fwd_score;
      2'd3:    dval = in_res ? frz_shots : shots;
      default: dval = 3'd0;
    endcase
  end

  seg7_decode u_dec (.val(dval), .seg(dseg));

`ifdef SCOREBOARD_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] bcnt;
  logic          phase, phase_nxt, bwrap;

  assign bwrap     = (bcnt == BW'(BLINK_DIV - 1));
  assign phase_nxt = (in_res && tick && bwrap) ? ~phase : phase;
  assign blank     = phase_nxt &&
                     ((idx_nxt == 2'd0 && (winner == WIN_GK  || winner == WIN_TIE)) ||
                      (idx_nxt == 2'd1 && (winner == WIN_FWD || winner == WIN_TIE)));

  // Blink counter runs on scan ticks in RESULT only; parked at zero otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (!in_res) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      bcnt  <= bwrap ? '0 : bcnt + 1'b1;
      phase <= phase_nxt;
    end
  end
`else
  assign blank = 1'b0;
`endif

  // Registered display outputs track the index as it is updated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= SEG_BLANK;
      an  <= 4'hF;
    end else begin
      seg <= (idx_nxt == 2'd2) ? SEG_DASH : (blank ? SEG_BLANK : dseg);
      an  <= ~(4'b0001 << idx_nxt);
    end
  end

endmodule
